// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared state encoding, button indices and default timing
package button_conditioner_pkg;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRESS_DB   = 3'd1;
  localparam logic [2:0] ST_HOLD       = 3'd2;
  localparam logic [2:0] ST_REPEAT     = 3'd3;
  localparam logic [2:0] ST_RELEASE_DB = 3'd4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_HOLD_CYCLES     = 25000000;
  localparam int DEF_REPEAT_CYCLES   = 5000000;
  localparam int DEF_CNT_W           = 25;
endpackage

// File: rtl/button_channel.sv
// button_channel: one button's synchronizer, debounce/auto-repeat FSM and counter
module button_channel import button_conditioner_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic held
);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_C = CNT_W'(REPEAT_CYCLES);
  logic [1:0] sync_ff;
  logic sync;
  logic [2:0] state, state_d, ret, ret_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc, tgt;
  logic fire, pulse_q;
  assign sync = sync_ff[1];
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign tgt = state == ST_HOLD ? HLD_C : REP_C;
  // state, counter, return state, synchronizer and pulse registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_ff <= '0;
      state   <= ST_IDLE;
      cnt     <= '0;
      ret     <= ST_HOLD;
      pulse_q <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      state   <= state_d;
      cnt     <= cnt_d;
      ret     <= ret_d;
      pulse_q <= fire;
    end
  end
  // next state: debounce both edges, then hold delay and periodic repeat
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ret_d   = ret;
    fire    = 1'b0;
    case (state)
      ST_IDLE: begin
        state_d = sync ? ST_PRESS_DB : ST_IDLE;
        cnt_d   = sync ? CNT_W'(1) : '0;
      end
      ST_PRESS_DB: begin
        if (!sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_C) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          fire    = 1'b1;
        end else cnt_d = cnt_inc;
      end
      ST_HOLD, ST_REPEAT: begin
        if (!sync) begin
          ret_d   = state;
          state_d = ST_RELEASE_DB;
          cnt_d   = CNT_W'(1);
        end else if (cnt_inc >= tgt) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          fire    = 1'b1;
        end else cnt_d = cnt_inc;
      end
      ST_RELEASE_DB: begin
        if (sync) begin
          state_d = ret;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // outputs: debounced level stays up until the release is accepted
  always_comb begin
    pulse = pulse_q;
    held  = state == ST_HOLD || state == ST_REPEAT || state == ST_RELEASE_DB;
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: four independent button channels with enable-gated registered pulses
module button_conditioner import button_conditioner_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] raw_buttons,
  output logic       up_button,
  output logic       down_button,
  output logic       left_button,
  output logic       right_button,
  output logic [3:0] held
);
  logic [3:0] pulse, level;
  for (genvar i = 0; i < 4; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(raw_buttons[i]),
      .pulse(pulse[i]),
      .held(level[i])
    );
  end
  // register outputs; a pulse masked by enable is dropped, not queued
  always_ff @(posedge clk) begin
    if (!reset) begin
      {up_button, down_button, left_button, right_button} <= 4'b0;
      held <= 4'b0;
    end else begin
      up_button    <= pulse[BTN_UP] & enable;
      down_button  <= pulse[BTN_DOWN] & enable;
      left_button  <= pulse[BTN_LEFT] & enable;
      right_button <= pulse[BTN_RIGHT] & enable;
      held         <= level;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: per-cycle vector table plus hand-written reset/latency sequences
module tb_button_conditioner;
  localparam int N = 380;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic [3:0] raw_buttons = 4'b0;
  logic up_button, down_button, left_button, right_button;
  logic [3:0] held, pulses;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic rst_n;
    logic en;
    logic [3:0] raw;
    logic [3:0] exp_p;
    logic [3:0] exp_h;
  } vec_t;
  vec_t v [N];

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8),
    .CNT_W(25)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .raw_buttons(raw_buttons),
    .up_button(up_button),
    .down_button(down_button),
    .left_button(left_button),
    .right_button(right_button),
    .held(held)
  );

  assign pulses = {up_button, down_button, left_button, right_button};

  task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void set_raw(int b, int from, int to);
    for (int i = from; i <= to; i++) v[i].raw[b] = 1'b1;
  endfunction

  function automatic void set_h(int b, int from, int to);
    for (int i = from; i <= to; i++) v[i].exp_h[b] = 1'b1;
  endfunction

  function automatic void set_p(int b, int row);
    v[row].exp_p[b] = 1'b1;
  endfunction

  initial begin
    int n;
    for (int i = 0; i < N; i++) v[i] = '{1'b1, 1'b1, 4'b0, 4'b0, 4'b0};
    for (int i = 0; i < 3; i++) v[i].rst_n = 1'b0;
    // single up press, 10 cycles
    set_raw(3, 10, 19); set_p(3, 16); set_h(3, 16, 25);
    // left glitch train: 3 high / 1 low, five times
    for (int k = 0; k < 5; k++) set_raw(1, 40 + 4 * k, 42 + 4 * k);
    // down held 60 cycles: first press, hold, then repeats
    set_raw(2, 70, 129); set_h(2, 76, 135);
    set_p(2, 76); set_p(2, 96); set_p(2, 104); set_p(2, 112); set_p(2, 120); set_p(2, 128);
    // up and right together
    set_raw(3, 150, 159); set_raw(0, 150, 159);
    set_p(3, 156); set_p(0, 156); set_h(3, 156, 165); set_h(0, 156, 165);
    // right held with enable low across the first pulse
    set_raw(0, 180, 217); set_h(0, 186, 223);
    for (int i = 182; i <= 190; i++) v[i].en = 1'b0;
    set_p(0, 206); set_p(0, 214);
    // up held, reset pulse while repeating, fresh press afterwards
    set_raw(3, 240, 299); set_h(3, 246, 277); set_h(3, 285, 305);
    set_p(3, 246); set_p(3, 266); set_p(3, 274); set_p(3, 285);
    v[278].rst_n = 1'b0;
    // left held, short release glitch returns to hold with cleared counter
    set_raw(1, 320, 339); set_raw(1, 342, 355); set_p(1, 326); set_h(1, 326, 361);

    for (int i = 0; i < N; i++) begin
      reset = v[i].rst_n;
      enable = v[i].en;
      raw_buttons = v[i].raw;
      step();
      check("pulses", i, 32'(pulses), 32'(v[i].exp_p));
      check("held", i, 32'(held), 32'(v[i].exp_h));
    end

    // reset during press debounce: progress must be discarded
    raw_buttons = 4'b1000;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_pulses", 0, 32'(pulses), 32'(0));
    check("rst_held", 0, 32'(held), 32'(0));
    reset = 1'b1;
    n = 0;
    while (n < 20 && up_button !== 1'b1) begin
      step();
      n++;
    end
    check("relatch_latency", n, n, 7);
    check("relatch_held", n, 32'(held), 32'(4'b1000));
    step();
    check("single_cycle", 0, 32'(pulses), 32'(0));
    raw_buttons = 4'b0000;
    n = 0;
    while (n < 20 && held !== 4'b0000) begin
      step();
      n++;
    end
    check("release_latency", n, n, 7);
    check("release_pulses", 0, 32'(pulses), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
